// File: rtl/relay_pkg.sv
// Shared fetch-stage types and helpers: FSM state encoding, halt opcode
// default and the instruction length decoder.
package relay_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_HI,
    S_FETCH_LO,
    S_HOLD,
    S_HALT
  } fetch_state_t;

  localparam logic [7:0] OP_HALT_DEFAULT = 8'hAE;
  localparam logic [1:0] GOTO_MASK       = 2'b11;

  // GOTO-family opcodes carry a 16-bit immediate; everything else is 1 byte.
  function automatic logic [1:0] instr_len(input logic [7:0] op);
    return (op[7:6] == GOTO_MASK) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/pc_register.sv
// 16-bit program counter: synchronous reset, load (priority) and increment
// with natural wrap from 16'hFFFF to 16'h0000.
module pc_register #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        inc,
  output logic [15:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: walks the PC over memory, captures opcode and
// optional immediate, and hands a complete instruction to decode.
module fetch_sequencer
  import relay_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [7:0]  OP_HALT  = OP_HALT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        addr_oe,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic        halted
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic         pc_ld;
  logic         pc_inc;
  logic         fetching;

  pc_register #(
    .RESET_VAL (PC_RESET)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (pc_ld),
    .load_value (pc_load_value),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // pc_load is honoured only where the PC is not being walked by a fetch.
  always_comb begin
    next_state = state;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        pc_ld = pc_load;
        if (run) begin
          next_state = S_FETCH_OP;
        end
      end
      S_FETCH_OP: begin
        pc_inc     = 1'b1;
        next_state = (instr_len(mem_rdata) == 2'd3) ? S_FETCH_HI : S_HOLD;
      end
      S_FETCH_HI: begin
        pc_inc     = 1'b1;
        next_state = S_FETCH_LO;
      end
      S_FETCH_LO: begin
        pc_inc     = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_ld      = pc_load;
          next_state = (opcode == OP_HALT) ? S_HALT : S_FETCH_OP;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opcode <= 8'h00;
      imm    <= 16'h0000;
    end else begin
      case (state)
        S_FETCH_OP: begin
          opcode <= mem_rdata;
          imm    <= 16'h0000;
        end
        S_FETCH_HI: imm[15:8] <= mem_rdata;
        S_FETCH_LO: imm[7:0]  <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Bus outputs decode straight from the registered state so they are glitch-free.
  assign fetching    = (state == S_FETCH_OP) || (state == S_FETCH_HI) ||
                       (state == S_FETCH_LO);
  assign mem_addr    = fetching ? pc : 16'h0000;
  assign mem_read    = fetching;
  assign addr_oe     = fetching;
  assign instr_valid = (state == S_HOLD);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-position reference model
// checked every cycle, plus literal spot checks.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        addr_oe;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        halted;

  logic [7:0] mem [0:32767];
  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          started = 0;
  bit          m_fetch, m_valid, m_halt;
  int          m_pos, m_len;
  logic [15:0] m_pc, m_imm;
  logic [7:0]  m_op, b;

  fetch_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_rdata     (mem_rdata),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .addr_oe       (addr_oe),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .imm           (imm),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[14:0]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: an instruction is fetched byte by byte at m_pc; m_pos counts bytes taken.
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      started = 1;
      m_fetch = 0; m_valid = 0; m_halt = 0;
      m_pos = 0; m_len = 1;
      m_pc = 16'h0000; m_op = 8'h00; m_imm = 16'h0000;
    end else if (m_fetch) begin
      b = mem[m_pc[14:0]];
      if (m_pos == 0) begin
        m_op = b; m_imm = 16'h0000;
        m_len = (b >= 8'hC0) ? 3 : 1;
      end else if (m_pos == 1) begin
        m_imm[15:8] = b;
      end else begin
        m_imm[7:0] = b;
      end
      m_pc = m_pc + 16'd1;
      m_pos++;
      if (m_pos == m_len) begin
        m_fetch = 0; m_valid = 1;
      end
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid = 0;
        if (m_op == 8'hAE) m_halt = 1;
        else begin m_fetch = 1; m_pos = 0; end
        if (pc_load) m_pc = pc_load_value;
      end
    end else begin
      if (pc_load) m_pc = pc_load_value;
      if (run) begin m_fetch = 1; m_pos = 0; m_halt = 0; end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (started) begin
      chk("mem_addr", mem_addr, m_fetch ? m_pc : 16'h0000);
      chk("mem_read", mem_read, m_fetch);
      chk("addr_oe", addr_oe, m_fetch);
      chk("instr_valid", instr_valid, m_valid);
      chk("opcode", opcode, m_op);
      chk("imm", imm, m_imm);
      chk("pc", pc, m_pc);
      chk("halted", halted, m_halt);
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[0] = 8'h21;
    mem[4] = 8'hC0; mem[5] = 8'h12; mem[6] = 8'h34;
    mem[7] = 8'h01; mem[8] = 8'h02;
    mem[16'h1234] = 8'h05;
    mem[16'h7FFF] = 8'h10;
    reset_n = 1'b0; run = 1'b0; pc_load = 1'b0;
    pc_load_value = 16'h0000; instr_ready = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_oe", addr_oe, 1'b0);

    // First 1-byte fetch from address 0
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("f0_read", mem_read, 1'b1);
    chk("f0_addr", mem_addr, 16'h0000);
    step(1);
    chk("f0_valid", instr_valid, 1'b1);
    chk("f0_op", opcode, 8'h21);
    chk("f0_imm", imm, 16'h0000);
    chk("f0_pc", pc, 16'h0001);

    // Jump to 4 on accept, then 3-byte fetch; pc_load during fetch is ignored
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_value = 16'h0004;
    step(1);
    instr_ready = 1'b0; pc_load_value = 16'h5555;
    chk("g_addr4", mem_addr, 16'h0004);
    step(1);
    pc_load = 1'b0;
    chk("g_addr5", mem_addr, 16'h0005);
    step(1);
    chk("g_addr6", mem_addr, 16'h0006);
    step(1);
    chk("g_op", opcode, 8'hC0);
    chk("g_imm", imm, 16'h1234);
    chk("g_pc", pc, 16'h0007);

    // Stall in HOLD; run and unaccepted pc_load must not disturb anything
    for (int i = 0; i < 5; i++) begin
      run = (i == 2); pc_load = (i == 3); pc_load_value = 16'h0BAD;
      step(1);
      chk("hold_valid", instr_valid, 1'b1);
      chk("hold_op", opcode, 8'hC0);
      chk("hold_imm", imm, 16'h1234);
      chk("hold_read", mem_read, 1'b0);
      chk("hold_oe", addr_oe, 1'b0);
    end
    run = 1'b0;

    instr_ready = 1'b1; pc_load = 1'b1; pc_load_value = 16'h1234;
    step(1);
    instr_ready = 1'b0; pc_load = 1'b0;
    chk("jmp_addr", mem_addr, 16'h1234);
    step(1);
    chk("jmp_op", opcode, 8'h05);
    chk("jmp_pc", pc, 16'h1235);

    // Wrap at 16'hFFFF
    instr_ready = 1'b1; pc_load = 1'b1; pc_load_value = 16'hFFFF;
    step(1);
    instr_ready = 1'b0; pc_load = 1'b0;
    chk("wrap_addr", mem_addr, 16'hFFFF);
    step(1);
    chk("wrap_op", opcode, 8'h10);
    chk("wrap_pc", pc, 16'h0000);

    // Halt, then resume with run
    mem[0] = 8'hAE; mem[1] = 8'h22;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(1);
    chk("halt_op", opcode, 8'hAE);
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    chk("halted", halted, 1'b1);
    chk("halt_read", mem_read, 1'b0);
    step(2);
    chk("halt_stay", halted, 1'b1);
    run = 1'b1;
    step(1);
    run = 1'b0;
    chk("resume_addr", mem_addr, 16'h0001);
    chk("resume_halt", halted, 1'b0);
    step(1);
    chk("resume_op", opcode, 8'h22);
    chk("resume_pc", pc, 16'h0002);

    // Reset during FETCH_HI
    mem[2] = 8'hC1; mem[3] = 8'hAA;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(1);
    chk("mid_addr", mem_addr, 16'h0003);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("mid_pc", pc, 16'h0000);
    chk("mid_op", opcode, 8'h00);
    chk("mid_imm", imm, 16'h0000);
    chk("mid_read", mem_read, 1'b0);
    chk("mid_valid", instr_valid, 1'b0);
    step(1);

    // Simultaneous run and pc_load from IDLE, then back-to-back 1-byte fetches
    run = 1'b1; pc_load = 1'b1; pc_load_value = 16'h0004;
    step(1);
    run = 1'b0; pc_load = 1'b0;
    chk("rl_addr", mem_addr, 16'h0004);
    step(3);
    chk("rl_imm", imm, 16'h1234);
    instr_ready = 1'b1;
    step(2);
    chk("ss_op1", opcode, 8'h01);
    chk("ss_valid1", instr_valid, 1'b1);
    step(2);
    chk("ss_op2", opcode, 8'h02);
    instr_ready = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch stage directly upstream of the 32 KB memory: drives the address bus from the program counter, asserts memory read, captures opcode and any 16-bit immediate bytes, and presents a complete instruction to decode/execute with a valid/ready handshake. The bus is released between fetches so the execute stage can use memory for LOAD/STORE. Absolute jumps and halt are handled here.

## Interface

Parameters:
- PC_RESET, 16'h0000, PC value after reset.
- OP_HALT, 8'hAE, opcode that stops fetching once accepted.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- run  in  1  one-cycle pulse; starts fetching from IDLE or HALT.
- pc_load  in  1  load PC from pc_load_value (jump/GOTO resolution).
- pc_load_value  in  16  new PC.
- mem_rdata  in  8  byte returned by memory; combinational with address.
- mem_addr  out  16  address to memory; bit 15 is ignored by memory.
- mem_read  out  1  memory read strobe.
- addr_oe  out  1  fetch owns the address bus; 0 means execute may drive.
- instr_valid  out  1  instruction and immediate are stable.
- instr_ready  in  1  decode accepts the instruction.
- opcode  out  8  captured opcode.
- imm  out  16  captured immediate, {hi, lo}; 0 for 1-byte instructions.
- pc  out  16  current program counter.
- halted  out  1  high in HALT.

## Operation

- Length rule: opcode[7:6] == 2'b11 is a 3-byte instruction (GOTO family: opcode, imm hi, imm lo); all others are 1 byte.
- States: IDLE, FETCH_OP, FETCH_HI, FETCH_LO, HOLD, HALT.
- IDLE: bus released. pc_load updates PC. run moves to FETCH_OP.
- FETCH_OP: mem_addr = pc, mem_read = 1, addr_oe = 1. Capture mem_rdata into opcode, clear imm, pc <= pc + 1. Next state is FETCH_HI for 3-byte instructions, else HOLD.
- FETCH_HI / FETCH_LO: same bus drive. Capture imm[15:8] then imm[7:0]. pc increments each cycle. FETCH_LO then goes to HOLD.
- HOLD: instr_valid = 1, bus released, opcode/imm held stable.
  - On instr_ready: if opcode == OP_HALT go to HALT, else go to FETCH_OP.
  - pc_load in the same cycle as instr_ready sets pc <= pc_load_value. The next FETCH_OP uses the loaded value.
- HALT: halted = 1, bus released. pc_load updates PC. run goes to FETCH_OP.
- PC arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000. No carry out.
- Ignored inputs: pc_load in FETCH_* states, and in HOLD without instr_ready. run outside IDLE and HALT.
- Simultaneous run and pc_load in IDLE or HALT: PC is loaded and FETCH_OP follows, fetching from the loaded address.
- mem_write is never driven by this block.

## Timing

- Reset (reset_n low at a rising edge) gives:
  - state IDLE, pc = PC_RESET, opcode = 0, imm = 0;
  - mem_addr = 0, mem_read = 0, addr_oe = 0, instr_valid = 0, halted = 0.
- Reset mid-fetch or in HOLD aborts with no instruction delivered. Reset dominates all inputs.
- Outputs are registered from state. mem_addr equals pc during FETCH_* cycles and 0 otherwise.
- Latency from run (or from instr_ready) to instr_valid:
  - 2 cycles for a 1-byte instruction (FETCH_OP, then HOLD);
  - 4 cycles for a 3-byte instruction.
- Steady state: 1-byte instructions every 2 cycles with instr_ready held high.
- instr_valid stays high and opcode/imm stay unchanged until the cycle instr_ready is sampled high.

## Structure

- Shared package relay_pkg holds:
  - the fetch_state_t enum;
  - the OP_HALT default and the GOTO-class mask 2'b11;
  - a function instr_len(opcode) returning 1 or 3.
- One sub-module, pc_register: 16-bit PC with reset value, load, and increment (load has priority), plus wrap.
- The FSM and capture registers live in fetch_sequencer.

## Test plan

- Reset, then run with memory[0] = 8'h21: FETCH_OP at addr 0, then instr_valid with opcode 8'h21 and imm 0; pc = 1.
- memory[4..6] = C0 12 34, pc = 4: three read cycles at addresses 4, 5, 6, then opcode C0, imm 16'h1234, pc = 7. pc_load 16'h1234 with instr_ready: next fetch addresses 16'h1234.
- Hold instr_ready low for 5 cycles in HOLD: instr_valid, opcode and imm stay constant, mem_read = 0, addr_oe = 0.
- pc = 16'hFFFF, 1-byte opcode: fetch at 16'hFFFF, pc wraps to 16'h0000.
- Opcode AE accepted: halted = 1 and no mem_read. A run pulse resumes fetching at the next pc.
- reset_n low during FETCH_HI: next cycle all outputs at reset values and pc = PC_RESET.
